// File: rtl/command_initiator.sv
// Host-side ASCII register-access initiator: serialises write/read frames to a UART byte
// transmitter and decodes the hex read response. Optional read timeout via `define RD_TIMEOUT_EN.
module command_initiator #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wr_data,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  busy
);

    localparam int ADDR_CHARS = ADDR_WIDTH / 4;
    localparam int DATA_CHARS = DATA_WIDTH / 4;
    localparam int MAX_CHARS  = (ADDR_CHARS > DATA_CHARS) ? ADDR_CHARS : DATA_CHARS;
    localparam int CW         = $clog2(MAX_CHARS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CMD, S_DATA, S_LF, S_WAIT
    } state_t;

    state_t                  state, next_state;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CW-1:0]           cnt;
    logic                    rx_hex;
    logic [3:0]              rx_nib;
    logic                    rx_take;
    logic                    tx_fire;
    logic                    timeout;

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        rx_hex = 1'b1;
        rx_nib = 4'h0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39)
            rx_nib = rx_byte[3:0];
        else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) || (rx_byte >= 8'h61 && rx_byte <= 8'h66))
            rx_nib = rx_byte[3:0] + 4'd9;
        else
            rx_hex = 1'b0;
    end

    assign rx_take = (state == S_WAIT) && rx_valid;
    assign tx_fire = tx_valid && tx_ready;

`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer <= '0;
        else if (state != S_WAIT || rx_take)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    // Fires on the edge where the count would reach TIMEOUT_CYCLES; a char arriving wins.
    assign timeout = (state == S_WAIT) && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (cmd_valid) next_state = S_ADDR;
            S_ADDR: if (tx_ready && cnt == CW'(ADDR_CHARS - 1)) next_state = S_CMD;
            S_CMD:  if (tx_ready) next_state = rw_q ? S_WAIT : S_DATA;
            S_DATA: if (tx_ready && cnt == CW'(DATA_CHARS - 1)) next_state = S_LF;
            S_LF:   if (tx_ready) next_state = S_IDLE;
            S_WAIT: begin
                if (rx_valid && (!rx_hex || cnt == CW'(DATA_CHARS - 1)))
                    next_state = S_IDLE;
                else if (timeout)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        tx_valid  = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            S_ADDR: begin
                tx_valid = 1'b1;
                tx_byte  = hex_enc(addr_q[ADDR_WIDTH-1 -: 4]);
            end
            S_CMD: begin
                tx_valid = 1'b1;
                tx_byte  = rw_q ? 8'h40 : 8'h21;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = hex_enc(data_q[DATA_WIDTH-1 -: 4]);
            end
            S_LF: begin
                tx_valid = 1'b1;
                tx_byte  = 8'h0A;
            end
            default: ;
        endcase
    end

    // Address/data are shifted left per transfer so the outgoing nibble is always the top one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (state == S_IDLE && cmd_valid) begin
                rw_q   <= cmd_rw;
                addr_q <= cmd_addr;
                data_q <= cmd_wr_data;
                if (cmd_rw)
                    rd_data <= '0;
            end
            if (state != next_state)
                cnt <= '0;
            else if (tx_fire || rx_take)
                cnt <= cnt + 1'b1;
            if (tx_fire && state == S_ADDR)
                addr_q <= addr_q << 4;
            if (tx_fire && state == S_DATA)
                data_q <= data_q << 4;
            if (rx_take) begin
                if (rx_hex)
                    rd_data <= (rd_data << 4) | DATA_WIDTH'(rx_nib);
                if (!rx_hex || cnt == CW'(DATA_CHARS - 1)) begin
                    rd_valid <= 1'b1;
                    rd_err   <= !rx_hex;
                end
            end else if (timeout) begin
                rd_valid <= 1'b1;
                rd_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_command_initiator.sv
// Randomised bench for command_initiator: expected frames and read results come from a
// byte-level protocol model; a monitor records every tx transfer and rd_valid pulse.
module tb_command_initiator;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int AN = AW / 4;
    localparam int DN = DW / 4;
    localparam int TO = 100;

    logic          clk, reset;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wr_data;
    logic [7:0]    tx_byte;
    logic          tx_valid, tx_ready;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_err, busy;

    command_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .busy(busy)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            rnd_ready = 0;
    logic [7:0]    obs_q[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    rsp_q[$];
    int            at_cnt = 0, at_cyc = 0, rdv_cnt = 0, rdv_cyc = 0;
    logic [DW-1:0] rdv_data = '0;
    logic          rdv_err = 1'b0, rdv_rdy = 1'b0;
    logic          stall_prev = 1'b0;
    logic [7:0]    stall_byte = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("tx_hold", {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, stall_byte});
            stall_prev = tx_valid && !tx_ready;
            stall_byte = tx_byte;
            if (tx_valid && tx_ready) begin
                obs_q.push_back(tx_byte);
                if (tx_byte == 8'h40) begin
                    at_cnt++;
                    at_cyc = cyc;
                end
            end
            if (rd_valid) begin
                rdv_cnt++;
                rdv_cyc  = cyc;
                rdv_data = rd_data;
                rdv_err  = rd_err;
                rdv_rdy  = cmd_ready;
            end
        end
    end

    function automatic logic [7:0] hex_char(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int hex_val(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    task automatic build_exp(input bit rw, input int a, input int d);
        exp_q.delete();
        for (int i = 0; i < AN; i++) exp_q.push_back(hex_char((a >> (4 * (AN - 1 - i))) & 15));
        if (rw) begin
            exp_q.push_back(8'h40);
        end else begin
            exp_q.push_back(8'h21);
            for (int i = 0; i < DN; i++) exp_q.push_back(hex_char((d >> (4 * (DN - 1 - i))) & 15));
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic compare_frame(input string tag);
        chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic send_cmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wr_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = AW'($urandom); cmd_wr_data = DW'($urandom);
        chk("ready_fall", 32'(cmd_ready), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rnd);
        int r0, lat;
        bit done;
        done = 0; lat = 0;
        rnd_ready = rnd;
        obs_q.delete();
        r0 = rdv_cnt;
        build_exp(0, int'(a), int'(d));
        send_cmd(1'b0, a, d);
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                done = 1; lat = i;
                break;
            end
        end
        chk("wr_done", 32'(done), 32'd1);
        if (!rnd) chk("wr_latency", 32'(lat), 32'd11);
        @(posedge clk); #1;
        rnd_ready = 0;
        compare_frame("wr");
        chk("wr_no_rdv", 32'(rdv_cnt - r0), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit stray, input bit rnd);
        int r0, a0, ev, ee;
        ev = 0; ee = 0;
        foreach (rsp_q[i]) begin
            if (!is_hex(rsp_q[i])) begin
                ee = 1;
                break;
            end
            ev = ((ev << 4) | hex_val(rsp_q[i])) & ((1 << DW) - 1);
        end
        rnd_ready = rnd;
        obs_q.delete();
        r0 = rdv_cnt;
        a0 = at_cnt;
        build_exp(1, int'(a), 0);
        send_cmd(1'b1, a, DW'($urandom));
        if (stray) begin
            rx_byte = 8'h31; rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
        for (int i = 0; i < 600 && at_cnt == a0; i++) begin
            @(posedge clk); #1;
        end
        chk("rd_at_sent", 32'(at_cnt - a0), 32'd1);
        foreach (rsp_q[i]) begin
            rx_byte = rsp_q[i]; rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 20 && rdv_cnt == r0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        rnd_ready = 0;
        chk("rd_pulse", 32'(rdv_cnt - r0), 32'd1);
        chk("rd_data", 32'(rdv_data), 32'(ev));
        chk("rd_err", 32'(rdv_err), 32'(ee));
        chk("rd_idle", 32'(rdv_rdy), 32'd1);
        compare_frame("rd");
    endtask

    initial begin
        int r0, a0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
        rx_byte = 8'h00; rx_valid = 1'b0;
        #2;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txb", 32'(tx_byte), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_rderr", 32'(rd_err), 32'd0);
        chk("rst_rdd", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_write(16'h1234, 16'hABCD, 0);
        rsp_q = '{8'h42, 8'h45, 8'h45, 8'h46};
        do_read(16'h00F0, 0, 0);
        rsp_q = '{8'h62, 8'h65, 8'h65, 8'h66};
        do_read(16'h00F0, 0, 0);
        rsp_q = '{8'h42, 8'h45, 8'h45, 8'h46};
        do_read(16'h5A5A, 1, 0);
        rsp_q = '{8'h31, 8'h32, 8'h5A};
        do_read(16'h0F00, 0, 0);
        do_write(16'hC0DE, 16'h1F2E, 1);

        // Reset lands right after the third address byte of a write.
        obs_q.delete();
        send_cmd(1'b0, 16'h1234, 16'h5678);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_txv", 32'(tx_valid), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_sent", 32'(obs_q.size()), 32'd3);
        @(posedge clk); #1 reset = 1'b0;
        do_write(16'h0001, 16'h0002, 0);

        obs_q.delete();
        r0 = rdv_cnt;
        a0 = at_cnt;
        send_cmd(1'b1, 16'h0042, 16'h0000);
        for (int i = 0; i < 100 && at_cnt == a0; i++) begin
            @(posedge clk); #1;
        end
`ifdef RD_TIMEOUT_EN
        for (int i = 0; i < 400 && rdv_cnt == r0; i++) begin
            @(posedge clk); #1;
        end
        chk("to_pulse", 32'(rdv_cnt - r0), 32'd1);
        chk("to_delay", 32'(rdv_cyc - at_cyc - 1), 32'(TO));
        chk("to_err", 32'(rdv_err), 32'd1);
        chk("to_data", 32'(rdv_data), 32'd0);
`else
        repeat (10000) @(posedge clk);
        #1;
        chk("to_busy", 32'(busy), 32'd1);
        chk("to_none", 32'(rdv_cnt - r0), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
`endif

        for (int t = 0; t < 24; t++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int errpos;
            a = AW'($urandom);
            d = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rsp_q.delete();
                errpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DN - 1)) : -1;
                for (int i = 0; i < DN; i++) begin
                    logic [7:0] b;
                    if (i == errpos) begin
                        do b = 8'($urandom); while (is_hex(b));
                        rsp_q.push_back(b);
                        break;
                    end
                    b = hex_char(int'($urandom_range(0, 15)));
                    if (b >= "A" && $urandom_range(0, 1) == 1) b = b + 8'h20;
                    rsp_q.push_back(b);
                end
                do_read(a, 0, 1'($urandom_range(0, 1)));
            end else begin
                do_write(a, d, 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
